// File: rtl/fanout_eager_fork.sv
// fanout_eager_fork: eager broadcast fork with a one-entry holding register.
// A held token is offered to every enabled, selected consumer. Each consumer's
// delivery is tracked in a done mask. The producer is released once every
// targeted branch has taken the token, and a refill can happen in that same cycle.
module fanout_eager_fork #(
    parameter int NUM_OUT = 7,
    parameter int WIDTH   = 16,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [NUM_OUT-1:0] in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NUM_OUT-1:0] out_en,
    output logic [WIDTH-1:0]   out_data,
    output logic [NUM_OUT-1:0] out_valid,
    input  logic [NUM_OUT-1:0] out_ready,
    output logic [CNT_W-1:0]   tok_count,
    output logic [CNT_W-1:0]   drop_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   data_q;
    logic [NUM_OUT-1:0] sel_q;
    logic [NUM_OUT-1:0] done_q;
    logic [CNT_W-1:0]   tok_q;
    logic [CNT_W-1:0]   drop_q;

    logic               full;
    logic [NUM_OUT-1:0] target;
    logic [NUM_OUT-1:0] fire;
    logic               complete;
    logic               accept;

    // Holding-register occupancy. Reset discards any held token.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Live routing, handshake decode and next occupancy.
    always_comb begin
        full      = (state_q == HELD);
        target    = out_en & sel_q;
        // Valid is forced low while reset is asserted, even before the first reset edge.
        out_valid = (rst_n && full) ? (target & ~done_q) : '0;
        fire      = out_valid & out_ready;
        complete  = full && (&(done_q | fire | ~target));
        in_ready  = rst_n && (!full || complete);
        accept    = in_valid && in_ready;
        state_d   = state_q;
        if (accept) begin
            state_d = HELD;
        end else if (complete) begin
            state_d = EMPTY;
        end
    end

    // Token payload is captured only on accept. in_sel changes while a token is held are ignored.
    always_ff @(posedge clk) begin
        if (accept) begin
            data_q <= in_data;
            sel_q  <= in_sel;
        end
    end

    // Per-branch delivery mask. It clears on refill or on drain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done_q <= '0;
        end else if (accept || complete) begin
            done_q <= '0;
        end else if (full) begin
            done_q <= done_q | fire;
        end
    end

    // Completion statistics. tok_count wraps and drop_count saturates.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tok_q  <= '0;
            drop_q <= '0;
        end else if (complete) begin
            if (|target) begin
                tok_q <= tok_q + CNT_W'(1);
            end else if (drop_q != '1) begin
                drop_q <= drop_q + CNT_W'(1);
            end
        end
    end

    assign out_data   = data_q;
    assign tok_count  = tok_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_fanout_eager_fork.sv
// Directed bench for fanout_eager_fork. The stimulus pushes each expected
// per-branch delivery into a queue for that branch. A negedge monitor pops the
// queue and compares on every handshake. Counters and valid patterns are
// checked against values worked out by hand.
module tb_fanout_eager_fork;

    localparam int NUM_OUT = 7;
    localparam int WIDTH   = 16;
    localparam int CNT_W   = 8;

    logic               clk;
    logic               rst_n;
    logic [WIDTH-1:0]   in_data;
    logic [NUM_OUT-1:0] in_sel;
    logic               in_valid;
    logic               in_ready;
    logic [NUM_OUT-1:0] out_en;
    logic [WIDTH-1:0]   out_data;
    logic [NUM_OUT-1:0] out_valid;
    logic [NUM_OUT-1:0] out_ready;
    logic [CNT_W-1:0]   tok_count;
    logic [CNT_W-1:0]   drop_count;

    int checks;
    int failures;

    logic [WIDTH-1:0] expq [NUM_OUT][$];

    fanout_eager_fork #(
        .NUM_OUT(NUM_OUT),
        .WIDTH  (WIDTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_en    (out_en),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .tok_count (tok_count),
        .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [NUM_OUT-1:0] mask, input logic [WIDTH-1:0] d);
        for (int i = 0; i < NUM_OUT; i++) begin
            if (mask[i]) expq[i].push_back(d);
        end
    endtask

    // Monitor: every handshake on a branch must match the next expected token for that branch.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                if (out_valid[i] && out_ready[i]) begin
                    if (expq[i].size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL extra_fire: branch %0d data 0x%0h, expected no delivery", i, out_data);
                    end else begin
                        chk($sformatf("deliver_b%0d", i), 32'(out_data), 32'(expq[i].pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_data   = '0;
        in_sel    = '0;
        in_valid  = 1'b0;
        out_en    = 7'h7F;
        out_ready = '0;

        // Reset state
        step();
        step();
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_tok", 32'(tok_count), 0);
        chk("rst_drop", 32'(drop_count), 0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 1);

        // Broadcast, all ready: four back-to-back tokens
        out_ready = 7'h7F;
        in_sel    = 7'h7F;
        for (int k = 1; k <= 4; k++) begin
            in_data  = 16'(k);
            in_valid = 1'b1;
            push(7'h7F, 16'(k));
            #1;
            chk("bc_in_ready", 32'(in_ready), 1);
            step();
            chk("bc_out_valid", 32'(out_valid), 32'h7F);
            chk("bc_out_data", 32'(out_data), 32'(k));
        end
        in_valid = 1'b0;
        step();
        chk("bc_idle_valid", 32'(out_valid), 0);
        chk("bc_tok", 32'(tok_count), 4);

        // Staggered consumers on branches 0..2
        out_ready = '0;
        in_data   = 16'hABCD;
        in_sel    = 7'h07;
        in_valid  = 1'b1;
        push(7'h07, 16'hABCD);
        step();
        in_valid  = 1'b0;
        out_ready = 7'h01;
        #1;
        chk("stg_valid_c1", 32'(out_valid), 32'h07);
        chk("stg_ready_c1", 32'(in_ready), 0);
        step();
        out_ready = 7'h03;
        #1;
        chk("stg_valid_c2", 32'(out_valid), 32'h06);
        chk("stg_ready_c2", 32'(in_ready), 0);
        step();
        out_ready = 7'h07;
        #1;
        chk("stg_valid_c3", 32'(out_valid), 32'h04);
        chk("stg_ready_c3", 32'(in_ready), 1);
        step();
        chk("stg_valid_end", 32'(out_valid), 0);
        chk("stg_tok", 32'(tok_count), 5);

        // Zero target: selected branches are all disabled
        out_en    = 7'h0F;
        out_ready = 7'h7F;
        in_data   = 16'h5555;
        in_sel    = 7'h30;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        #1;
        chk("zt_valid", 32'(out_valid), 0);
        chk("zt_in_ready", 32'(in_ready), 1);
        step();
        chk("zt_valid_after", 32'(out_valid), 0);
        chk("zt_drop", 32'(drop_count), 1);
        chk("zt_tok", 32'(tok_count), 5);
        out_en = 7'h7F;

        // Enable dropped mid-token on branch 1
        out_ready = 7'h01;
        in_data   = 16'h1234;
        in_sel    = 7'h03;
        in_valid  = 1'b1;
        push(7'h01, 16'h1234);
        step();
        in_valid = 1'b0;
        #1;
        chk("en_valid_c1", 32'(out_valid), 32'h03);
        chk("en_ready_c1", 32'(in_ready), 0);
        step();
        chk("en_valid_c2_before", 32'(out_valid), 32'h02);
        out_en = 7'h7D;
        #1;
        chk("en_valid_c2", 32'(out_valid), 0);
        chk("en_ready_c2", 32'(in_ready), 1);
        step();
        chk("en_tok", 32'(tok_count), 6);
        out_en = 7'h7F;

        // Reset while a token is half delivered
        out_ready = '0;
        in_data   = 16'h7777;
        in_sel    = 7'h03;
        in_valid  = 1'b1;
        push(7'h01, 16'h7777);
        step();
        in_valid  = 1'b0;
        out_ready = 7'h01;
        step();
        out_ready = '0;
        #1;
        chk("mr_half_valid", 32'(out_valid), 32'h02);
        rst_n = 1'b0;
        #1;
        chk("mr_valid_in_rst", 32'(out_valid), 0);
        chk("mr_ready_in_rst", 32'(in_ready), 0);
        step();
        chk("mr_tok", 32'(tok_count), 0);
        chk("mr_drop", 32'(drop_count), 0);
        chk("mr_valid_after_edge", 32'(out_valid), 0);
        rst_n = 1'b1;
        #1;
        chk("mr_ready_release", 32'(in_ready), 1);
        in_data  = 16'h0F0F;
        in_sel   = 7'h03;
        in_valid = 1'b1;
        push(7'h03, 16'h0F0F);
        step();
        in_valid = 1'b0;
        chk("mr_next_valid", 32'(out_valid), 32'h03);
        out_ready = 7'h03;
        step();
        chk("mr_next_done", 32'(out_valid), 0);
        chk("mr_next_tok", 32'(tok_count), 1);

        // Saturation and wrap with 8-bit counters
        rst_n = 1'b0;
        step();
        rst_n     = 1'b1;
        out_ready = 7'h7F;
        in_sel    = '0;
        in_data   = 16'h00AA;
        in_valid  = 1'b1;
        repeat (255) step();
        in_valid = 1'b0;
        step();
        chk("sat_drop_255", 32'(drop_count), 32'hFF);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("sat_drop_hold", 32'(drop_count), 32'hFF);
        chk("sat_tok_zero", 32'(tok_count), 0);
        in_sel   = 7'h01;
        in_valid = 1'b1;
        for (int k = 0; k < 256; k++) begin
            in_data = 16'(k);
            push(7'h01, 16'(k));
            step();
        end
        in_valid = 1'b0;
        step();
        chk("wrap_tok_256", 32'(tok_count), 0);
        in_data  = 16'hBEEF;
        in_valid = 1'b1;
        push(7'h01, 16'hBEEF);
        step();
        in_valid = 1'b0;
        step();
        chk("wrap_tok_257", 32'(tok_count), 1);
        chk("wrap_drop_final", 32'(drop_count), 32'hFF);

        // Every expected delivery must have been observed
        for (int i = 0; i < NUM_OUT; i++) begin
            chk($sformatf("drain_b%0d", i), 32'(expq[i].size()), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
